systolic_seq_ctrl: RTL and testbench

- Parametrised sequencing controller for the AXON 1-D systolic PE row.
- Accepts a start pulse plus run-time kernel length K and ifmap length N, then:
  - runs a skewed compute phase of K+N-1 cycles, with a per-PE ifmap-select window;
  - ejects PE outputs, either serially or as a single broadcast;
  - pulses finish.
- Sits between the AXI/loader front-end and the PE array; it replaces the fixed 31-cycle counter controller.

---
 rtl/systolic_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
//   Sequencing controller for the AXON 1-D systolic PE row. A start request
//   carries the kernel length K, the ifmap length N and the eject mode. The
//   controller then runs a skewed compute phase of L = K+N-1 cycles, ejects
//   the PE accumulators (serially or as one broadcast) and pulses finish.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous, active-high reset
//   start             one-cycle request, honoured only in IDLE
//   k_len, n_len      kernel / ifmap length, sampled with start
//   eject_mode        0 = serial eject, 1 = broadcast eject, sampled with start
//   ifmaps_sel        per-PE ifmap consume window
//   output_eject_ctrl per-PE accumulator drive enable
//   busy              high during COMPUTE and EJECT
//   finish            one-cycle completion pulse
//   cfg_err           one-cycle pulse when start carries a zero length
// -----------------------------------------------------------------------------
module systolic_seq_ctrl #(
   parameter int Dimension = 16,
   parameter int CW        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [CW-1:0]        k_len,
   input  logic [CW-1:0]        n_len,
   input  logic                 eject_mode,
   output logic [Dimension-1:0] ifmaps_sel,
   output logic [Dimension-1:0] output_eject_ctrl,
   output logic                 busy,
   output logic                 finish,
   output logic                 cfg_err
);

   localparam int EW   = $clog2(Dimension);
   localparam int LW   = CW + 1;
   // Window compare is widened so PE indices never wrap against the counter.
   localparam int CMPW = ((LW > EW + 1) ? LW : EW + 1) + 1;

   localparam logic [LW-1:0]        L_ONE   = LW'(1);
   localparam logic [EW-1:0]        E_ONE   = EW'(1);
   localparam logic [EW-1:0]        E_LAST  = EW'(Dimension - 1);
   localparam logic [Dimension-1:0] EJ_ONE  = {{(Dimension-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      EJECT   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t         state_r, state_s;
   logic [CW-1:0]  n_r, n_s;
   logic [LW-1:0]  l_r, l_s;
   logic           mode_r, mode_s;
   logic [LW-1:0]  c_r, c_s;
   logic [EW-1:0]  e_r, e_s;
   logic           cfg_err_s;

   logic [Dimension-1:0] sel_s;
   logic [Dimension-1:0] ej_s;
   logic [CMPW-1:0]      c_ext_s;
   logic [CMPW-1:0]      n_ext_s;

   // Next-state, counter and latched-configuration logic.
   always_comb begin
      state_s   = state_r;
      n_s       = n_r;
      l_s       = l_r;
      mode_s    = mode_r;
      c_s       = c_r;
      e_s       = e_r;
      cfg_err_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if ((k_len != {CW{1'b0}}) && (n_len != {CW{1'b0}})) begin
                  n_s     = n_len;
                  mode_s  = eject_mode;
                  l_s     = {1'b0, k_len} + {1'b0, n_len} - L_ONE;
                  c_s     = {LW{1'b0}};
                  state_s = COMPUTE;
               end else begin
                  cfg_err_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         COMPUTE: begin
            if (c_r == (l_r - L_ONE)) begin
               e_s     = {EW{1'b0}};
               state_s = EJECT;
            end else begin
               c_s = c_r + L_ONE;
            end
         end
         EJECT: begin
            // Broadcast ejects in a single cycle; serial walks every PE.
            if (mode_r || (e_r == E_LAST)) begin
               state_s = DONE;
            end else begin
               e_s = e_r + E_ONE;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Output decode from the next-state values so the outputs can be registered
   // and still line up with the cycle the state is entered.
   always_comb begin
      sel_s   = {Dimension{1'b0}};
      ej_s    = {Dimension{1'b0}};
      c_ext_s = CMPW'(c_s);
      n_ext_s = CMPW'(n_s);
      if (state_s == COMPUTE) begin
         for (int i = 0; i < Dimension; i++) begin
            sel_s[i] = ($unsigned(CMPW'(i)) <= c_ext_s) &&
                       (c_ext_s < ($unsigned(CMPW'(i)) + n_ext_s));
         end
      end else if (state_s == EJECT) begin
         if (mode_s) begin
            ej_s = {Dimension{1'b1}};
         end else begin
            ej_s = EJ_ONE << e_s;
         end
      end else begin
         sel_s = {Dimension{1'b0}};
         ej_s  = {Dimension{1'b0}};
      end
   end

   // State, counters, configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r           <= IDLE;
         n_r               <= {CW{1'b0}};
         l_r               <= {LW{1'b0}};
         mode_r            <= 1'b0;
         c_r               <= {LW{1'b0}};
         e_r               <= {EW{1'b0}};
         ifmaps_sel        <= {Dimension{1'b0}};
         output_eject_ctrl <= {Dimension{1'b0}};
         busy              <= 1'b0;
         finish            <= 1'b0;
         cfg_err           <= 1'b0;
      end else begin
         state_r           <= state_s;
         n_r               <= n_s;
         l_r               <= l_s;
         mode_r            <= mode_s;
         c_r               <= c_s;
         e_r               <= e_s;
         ifmaps_sel        <= sel_s;
         output_eject_ctrl <= ej_s;
         busy              <= (state_s == COMPUTE) || (state_s == EJECT);
         finish            <= (state_s == DONE);
         cfg_err           <= cfg_err_s;
      end
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
//   Directed bench for systolic_seq_ctrl (Dimension=16, CW=8). Expected values
//   are hand-computed tables and constants; every comparison goes through
//   check_eq.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  k_len;
   logic [7:0]  n_len;
   logic        eject_mode;
   logic [15:0] ifmaps_sel;
   logic [15:0] output_eject_ctrl;
   logic        busy;
   logic        finish;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;
   int compute_cycles;

   systolic_seq_ctrl #(.Dimension(16), .CW(8)) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .k_len             (k_len),
      .n_len             (n_len),
      .eject_mode        (eject_mode),
      .ifmaps_sel        (ifmaps_sel),
      .output_eject_ctrl (output_eject_ctrl),
      .busy              (busy),
      .finish            (finish),
      .cfg_err           (cfg_err)
   );

   // 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] sel, input logic [15:0] ej,
                          input logic bsy, input logic fin, input logic err);
      check_eq({tag, "_sel"},    32'(ifmaps_sel),        32'(sel));
      check_eq({tag, "_ej"},     32'(output_eject_ctrl), 32'(ej));
      check_eq({tag, "_busy"},   32'(busy),              32'(bsy));
      check_eq({tag, "_finish"}, 32'(finish),            32'(fin));
      check_eq({tag, "_cfgerr"}, 32'(cfg_err),           32'(err));
   endtask

   // Advance to one time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] ser_sel [6];
   logic [15:0] bc_sel  [3];

   // Directed stimulus and checks.
   initial begin
      ser_sel[0] = 16'h0001; ser_sel[1] = 16'h0003; ser_sel[2] = 16'h0007;
      ser_sel[3] = 16'h000F; ser_sel[4] = 16'h001E; ser_sel[5] = 16'h003C;
      bc_sel[0]  = 16'h0001; bc_sel[1]  = 16'h0003; bc_sel[2]  = 16'h0006;

      rst = 1'b1; start = 1'b0; k_len = 8'd0; n_len = 8'd0; eject_mode = 1'b0;

      // Reset held for three cycles, then start together with reset.
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("rst%0d", i), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      end
      start = 1'b1; k_len = 8'd3; n_len = 8'd4;
      step();
      chk_all("rst_start", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0; start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_all($sformatf("post_rst%0d", i), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      end

      // Serial run K=3 N=4; extra starts at cycle 3 (COMPUTE) and 23 (DONE).
      start = 1'b1; k_len = 8'd3; n_len = 8'd4; eject_mode = 1'b0;
      step();
      for (int t = 1; t <= 24; t++) begin
         if (t == 3 || t == 23) begin
            start = 1'b1; k_len = 8'd1; n_len = 8'd1; eject_mode = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (t <= 6)
            chk_all($sformatf("ser_c%0d", t), ser_sel[t-1], 16'h0000, 1'b1, 1'b0, 1'b0);
         else if (t <= 22)
            chk_all($sformatf("ser_c%0d", t), 16'h0000, 16'h0001 << (t - 7), 1'b1, 1'b0, 1'b0);
         else if (t == 23)
            chk_all("ser_c23", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
         else
            chk_all("ser_c24", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
         step();
      end
      start = 1'b0;
      chk_all("ser_c25", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Broadcast run K=2 N=2.
      start = 1'b1; k_len = 8'd2; n_len = 8'd2; eject_mode = 1'b1;
      step();
      start = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         chk_all($sformatf("bc_c%0d", t), bc_sel[t-1], 16'h0000, 1'b1, 1'b0, 1'b0);
         step();
      end
      chk_all("bc_c4", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("bc_c5", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      step();
      chk_all("bc_c6", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Configuration error: K=0.
      start = 1'b1; k_len = 8'd0; n_len = 8'd5; eject_mode = 1'b0;
      step();
      start = 1'b0;
      chk_all("cfg_c1", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
      for (int t = 2; t <= 4; t++) begin
         step();
         chk_all($sformatf("cfg_c%0d", t), 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      end

      // Minimum run K=N=1, serial: finish 18 cycles after start.
      start = 1'b1; k_len = 8'd1; n_len = 8'd1; eject_mode = 1'b0;
      step();
      start = 1'b0;
      chk_all("min_c1", 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0);
      for (int t = 2; t <= 17; t++) begin
         step();
         chk_all($sformatf("min_c%0d", t), 16'h0000, 16'h0001 << (t - 2), 1'b1, 1'b0, 1'b0);
      end
      step();
      chk_all("min_c18", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
      step();

      // Abort in EJECT: K=N=2 serial, reset sampled at the end of cycle 8.
      start = 1'b1; k_len = 8'd2; n_len = 8'd2; eject_mode = 1'b0;
      step();
      start = 1'b0;
      for (int t = 1; t < 8; t++) step();
      chk_all("abort_c8", 16'h0000, 16'h0010, 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_all("abort_c9", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
      for (int t = 10; t <= 30; t++) begin
         step();
         check_eq($sformatf("abort_fin_c%0d", t), 32'(finish), 32'd0);
         check_eq($sformatf("abort_busy_c%0d", t), 32'(busy), 32'd0);
      end

      // Maximum run K=N=255, broadcast: COMPUTE lasts 509 cycles.
      start = 1'b1; k_len = 8'd255; n_len = 8'd255; eject_mode = 1'b1;
      step();
      start = 1'b0;
      check_eq("max_sel_c1", 32'(ifmaps_sel), 32'h0001);
      compute_cycles = 0;
      for (int g = 0; g < 2000; g++) begin
         if (busy && (output_eject_ctrl == 16'h0000)) begin
            compute_cycles++;
            if (compute_cycles == 16)  check_eq("max_sel_c16",  32'(ifmaps_sel), 32'hFFFF);
            if (compute_cycles == 509) check_eq("max_sel_c509", 32'(ifmaps_sel), 32'h0000);
         end else begin
            break;
         end
         step();
      end
      check_eq("max_compute_len", 32'(compute_cycles), 32'd509);
      chk_all("max_eject", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      step();
      chk_all("max_done", 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
